// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin / fixed-select stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Channel-index width; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned channels);
        return (channels > 32'd2) ? 32'($clog2(channels)) : 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping to the lowest index.
module rr_arbiter #(
    parameter  int unsigned CHANNELS = 3,
    localparam int unsigned SELW     = stream_mux_pkg::sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [SELW-1:0]     last_grant_i,
    output logic [SELW-1:0]     grant_c,
    output logic                grant_valid_c
);

    logic            hi_found;
    logic            lo_found;
    logic [SELW-1:0] hi_idx;
    logic [SELW-1:0] lo_idx;

    // Lowest requester above last_grant wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (req_i[i] && !hi_found && (SELW'(i) > last_grant_i)) begin
                hi_found = 1'b1;
                hi_idx   = SELW'(i);
            end
            if (req_i[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = SELW'(i);
            end
        end
        grant_c       = hi_found ? hi_idx : lo_idx;
        grant_valid_c = |req_i;
    end

endmodule

// File: rtl/stream_mux_rr.sv
// Packet-aware N:1 stream multiplexer with round-robin or fixed channel selection
// and a single registered output stage.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int unsigned WIDTH    = 32,
    parameter  int unsigned CHANNELS = 3,
    localparam int unsigned SELW     = sel_width(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      MODE,
    input  logic [SELW-1:0]           SELECT,
    input  logic [CHANNELS-1:0]       IN_VALID,
    input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
    input  logic [CHANNELS-1:0]       IN_LAST,
    output logic [CHANNELS-1:0]       IN_READY,
    output logic                      OUT_VALID,
    output logic [WIDTH-1:0]          OUT_DATA,
    output logic                      OUT_LAST,
    output logic [SELW-1:0]           OUT_CHANNEL,
    input  logic                      OUT_READY
);

    state_e           state_q, state_d;
    logic [SELW-1:0]  lock_ch_q, lock_ch_d;
    logic [SELW-1:0]  last_grant_q, last_grant_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;

    logic [SELW-1:0]  rr_grant;
    logic             rr_valid;
    logic [SELW-1:0]  grant;
    logic             grant_valid;
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic             adv;
    logic             accept;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_rr_arbiter (
        .req_i         (IN_VALID),
        .last_grant_i  (last_grant_q),
        .grant_c       (rr_grant),
        .grant_valid_c (rr_valid)
    );

    // Grant selection and source mux; an out-of-range index matches no channel.
    always_comb begin
        grant     = rr_grant;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        IN_READY  = '0;

        if (state_q == LOCKED) begin
            grant = lock_ch_q;
        end else if (MODE == MODE_FIXED) begin
            grant = SELECT;
        end

        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant == SELW'(i)) begin
                sel_valid = IN_VALID[i];
                sel_last  = IN_LAST[i];
                sel_data  = IN_DATA[i*WIDTH +: WIDTH];
            end
        end

        grant_valid = ((state_q == IDLE) && (MODE == MODE_RR)) ? rr_valid : sel_valid;
        adv         = !out_valid_q || OUT_READY;
        accept      = grant_valid && adv && !RESET;

        for (int unsigned i = 0; i < CHANNELS; i++) begin
            IN_READY[i] = accept && (grant == SELW'(i));
        end
    end

    // Next-state: packet lock FSM, fairness pointer and output register load.
    always_comb begin
        state_d      = state_q;
        lock_ch_d    = lock_ch_q;
        last_grant_d = last_grant_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_ch_d     = out_ch_q;

        if (accept) begin
            if (sel_last) begin
                state_d      = IDLE;
                last_grant_d = grant;
            end else if (state_q == IDLE) begin
                state_d   = LOCKED;
                lock_ch_d = grant;
            end
        end

        if (adv) begin
            out_valid_d = accept;
            if (accept) begin
                out_data_d = sel_data;
                out_last_d = sel_last;
                out_ch_d   = grant;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            lock_ch_q    <= '0;
            last_grant_q <= SELW'(CHANNELS - 1);
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_ch_q     <= '0;
        end else begin
            state_q      <= state_d;
            lock_ch_q    <= lock_ch_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_ch_q     <= out_ch_d;
        end
    end

    assign OUT_VALID   = out_valid_q;
    assign OUT_DATA    = out_data_q;
    assign OUT_LAST    = out_last_q;
    assign OUT_CHANNEL = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: per-cycle vector table plus hand-written
// backpressure, reset and mode-change sequences.
module tb_stream_mux_rr;

    localparam int unsigned W  = 32;
    localparam int unsigned CH = 3;

    logic            clk;
    logic            rst;
    logic            mode;
    logic [1:0]      sel;
    logic [CH-1:0]   in_valid;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_last;
    logic [CH-1:0]   in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_last;
    logic [1:0]      out_channel;
    logic            out_ready;

    int checks;
    int errors;
    int cyc;

    stream_mux_rr #(
        .WIDTH    (W),
        .CHANNELS (CH)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .MODE        (mode),
        .SELECT      (sel),
        .IN_VALID    (in_valid),
        .IN_DATA     (in_data),
        .IN_LAST     (in_last),
        .IN_READY    (in_ready),
        .OUT_VALID   (out_valid),
        .OUT_DATA    (out_data),
        .OUT_LAST    (out_last),
        .OUT_CHANNEL (out_channel),
        .OUT_READY   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [2:0] valid;
        logic [2:0] last;
        logic       ordy;
        logic [2:0] rdy;
        logic       ov;
        logic [1:0] ch;
        logic       ol;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [2:0] v,
                                input logic [2:0] l, input logic r, input logic [2:0] er,
                                input logic eov, input logic [1:0] ech, input logic eol);
        vec_t t;
        t.mode = m;  t.sel = s;  t.valid = v;  t.last = l;  t.ordy = r;
        t.rdy  = er; t.ov  = eov; t.ch   = ech; t.ol  = eol;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Default data pattern: channel id, marker byte, cycle number.
    task automatic fill_data();
        for (int i = 0; i < int'(CH); i++)
            in_data[i*W +: W] = {8'(i), 8'hD0, 16'(cyc)};
    endtask

    // One cycle: drive at negedge, check IN_READY before the edge, outputs after it.
    task automatic step(input logic r, input logic m, input logic [1:0] s,
                        input logic [2:0] v, input logic [2:0] l, input logic ordy,
                        input logic [2:0] er, input logic eov, input logic [1:0] ech,
                        input logic eol, input string name);
        @(negedge clk);
        rst = r; mode = m; sel = s; in_valid = v; in_last = l; out_ready = ordy;
        fill_data();
        #1;
        chk({name, ".in_ready"}, 32'(in_ready), 32'(er));
        @(posedge clk);
        #1;
        chk({name, ".out_valid"}, 32'(out_valid), 32'(eov));
        chk({name, ".out_channel"}, 32'(out_channel), 32'(ech));
        chk({name, ".out_last"}, 32'(out_last), 32'(eol));
        cyc++;
    endtask

    int beat;
    logic [2:0] bp_rdy;
    int         bp_exp_beat;
    logic       bp_ov;

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = '0; in_last = '0;
        in_data = '0; out_ready = 1'b1;

        // mode sel valid last ordy | rdy ov ch last
        tbl[0]  = mk(1'b0, 2'd0, 3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1);
        tbl[1]  = mk(1'b0, 2'd0, 3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1);
        tbl[2]  = mk(1'b0, 2'd0, 3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 1'b1);
        tbl[3]  = mk(1'b0, 2'd0, 3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1);
        tbl[4]  = mk(1'b0, 2'd0, 3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1);
        tbl[5]  = mk(1'b0, 2'd0, 3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 1'b1);
        tbl[6]  = mk(1'b0, 2'd0, 3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1);
        tbl[7]  = mk(1'b0, 2'd0, 3'b111, 3'b101, 1'b1, 3'b010, 1'b1, 2'd1, 1'b0);
        tbl[8]  = mk(1'b0, 2'd0, 3'b111, 3'b101, 1'b1, 3'b010, 1'b1, 2'd1, 1'b0);
        tbl[9]  = mk(1'b0, 2'd0, 3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1);
        tbl[10] = mk(1'b0, 2'd0, 3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 1'b1);
        tbl[11] = mk(1'b1, 2'd2, 3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 1'b1);
        tbl[12] = mk(1'b1, 2'd2, 3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 1'b1);
        tbl[13] = mk(1'b1, 2'd3, 3'b111, 3'b111, 1'b1, 3'b000, 1'b0, 2'd2, 1'b1);
        tbl[14] = mk(1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 2'd2, 1'b1);
        tbl[15] = mk(1'b0, 2'd0, 3'b010, 3'b010, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1);
        tbl[16] = mk(1'b0, 2'd0, 3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1);

        // Reset state, with every channel requesting.
        in_valid = 3'b111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.in_ready", 32'(in_ready), 32'd0);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.out_data", out_data, 32'd0);
        chk("reset.out_last", 32'(out_last), 32'd0);
        chk("reset.out_channel", 32'(out_channel), 32'd0);

        for (int k = 0; k < 17; k++) begin
            step(1'b0, tbl[k].mode, tbl[k].sel, tbl[k].valid, tbl[k].last, tbl[k].ordy,
                 tbl[k].rdy, tbl[k].ov, tbl[k].ch, tbl[k].ol, $sformatf("vec%0d", k));
        end

        // Backpressure: ch1 streams single beats, OUT_READY low for cycles 1..4.
        beat = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rst = 1'b0; mode = 1'b0; sel = 2'd0; in_last = 3'b111;
            out_ready = (c >= 1 && c <= 4) ? 1'b0 : 1'b1;
            in_valid  = (c <= 6) ? 3'b010 : 3'b000;
            fill_data();
            in_data[1*W +: W] = 32'hB000_0000 + 32'(beat);
            bp_rdy      = (c == 0 || c == 5 || c == 6) ? 3'b010 : 3'b000;
            bp_exp_beat = (c <= 4) ? 0 : ((c == 5) ? 1 : 2);
            bp_ov       = (c <= 6);
            #1;
            chk($sformatf("bp%0d.in_ready", c), 32'(in_ready), 32'(bp_rdy));
            if (in_valid[1] && in_ready[1]) beat++;
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d.out_valid", c), 32'(out_valid), 32'(bp_ov));
            chk($sformatf("bp%0d.out_data", c), out_data, 32'hB000_0000 + 32'(bp_exp_beat));
            cyc++;
        end
        chk("bp.beats_sent", 32'(beat), 32'd3);

        // Reset in the middle of a 4-beat ch0 packet.
        step(1'b0, 1'b0, 2'd0, 3'b001, 3'b000, 1'b1, 3'b001, 1'b1, 2'd0, 1'b0, "rst.beat1");
        step(1'b0, 1'b0, 2'd0, 3'b001, 3'b000, 1'b1, 3'b001, 1'b1, 2'd0, 1'b0, "rst.beat2");
        step(1'b1, 1'b0, 2'd0, 3'b001, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0, "rst.assert");
        step(1'b0, 1'b0, 2'd0, 3'b110, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1, "rst.idle");
        step(1'b1, 1'b0, 2'd0, 3'b111, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0, "rst.again");
        step(1'b0, 1'b0, 2'd0, 3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1, "rst.prio0");

        // Mode switches to fixed while ch1 packet is in flight.
        step(1'b0, 1'b0, 2'd0, 3'b010, 3'b000, 1'b1, 3'b010, 1'b1, 2'd1, 1'b0, "mc.start");
        step(1'b0, 1'b1, 2'd2, 3'b111, 3'b101, 1'b1, 3'b010, 1'b1, 2'd1, 1'b0, "mc.mid");
        step(1'b0, 1'b1, 2'd2, 3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1, "mc.end");
        step(1'b0, 1'b1, 2'd2, 3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 1'b1, "mc.fixed");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
